// File: rtl/counter_193_driver.sv
// rtl/counter_193_driver.sv - valid/ready sequencer producing glitch-free npl/cpu/cpd pulse trains for a 74x193-style counter
//
// Ports:
//   clk, reset            single clock; synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake; ready only in IDLE and never while reset is high
//   cmd_op                00 nop, 01 load, 10 count up, 11 count down
//   cmd_data              parallel-load value (load)
//   cmd_len               number of count pulses (up/down)
//   npl, cpu, cpd         active-low load / count-up / count-down lines, idle high
//   p                     parallel data to the counter, held until the next load
//   ntcu, ntcd            counter terminal-count flags (active low), sampled at the end of each LO phase
//   done                  one-cycle strobe when a command finishes
//   wraps                 saturating count of terminal counts seen during the last command
//   abort                 present only with COUNTER_DRIVER_ABORT_EN: finish the current pulse, drop the rest
//
// Optional feature macro: COUNTER_DRIVER_ABORT_EN

module counter_193_driver #(
    parameter int WIDTH    = 4,
    parameter int CNTW     = 8,
    parameter int PULSE_LO = 1,
    parameter int PULSE_HI = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNTW-1:0]  cmd_len,
    output logic             npl,
    output logic             cpu,
    output logic             cpd,
    output logic [WIDTH-1:0] p,
    input  logic             ntcu,
    input  logic             ntcd,
`ifdef COUNTER_DRIVER_ABORT_EN
    input  logic             abort,
`endif
    output logic             done,
    output logic [CNTW-1:0]  wraps
);

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_UP   = 2'b10;
    localparam logic [1:0] OP_DOWN = 2'b11;

    // Phase counter counts down from (phase length - 1) to 0; sized for the longer phase.
    localparam int PMAX = (PULSE_LO > PULSE_HI) ? PULSE_LO : PULSE_HI;
    localparam int PW   = (PMAX > 1) ? $clog2(PMAX) : 1;
    localparam logic [PW-1:0] LO_LAST = PW'(PULSE_LO - 1);
    localparam logic [PW-1:0] HI_LAST = PW'(PULSE_HI - 1);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    state_t          state;
    logic [1:0]      op_q;
    logic [CNTW-1:0] remaining;
    logic [PW-1:0]   phase;
    logic            abort_req;
    logic            abort_now;

`ifdef COUNTER_DRIVER_ABORT_EN
    assign abort_now = abort;
`else
    assign abort_now = 1'b0;
`endif

    assign cmd_ready = (state == IDLE) && !reset;

    // {npl, cpu, cpd} with exactly the line belonging to op pulled low.
    function automatic logic [2:0] lines_for(input logic [1:0] op);
        case (op)
            OP_LOAD: lines_for = 3'b011;
            OP_UP:   lines_for = 3'b101;
            OP_DOWN: lines_for = 3'b110;
            default: lines_for = 3'b111;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            npl       <= 1'b1;
            cpu       <= 1'b1;
            cpd       <= 1'b1;
            p         <= '0;
            done      <= 1'b0;
            wraps     <= '0;
            op_q      <= OP_NOP;
            remaining <= '0;
            phase     <= '0;
            abort_req <= 1'b0;
        end else begin
            done <= 1'b0;
            // An abort is remembered so the pulse in flight still completes both phases.
            if ((state == LO || state == HI) && abort_now) begin
                abort_req <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q      <= cmd_op;
                        wraps     <= '0;
                        abort_req <= 1'b0;
                        phase     <= LO_LAST;
                        case (cmd_op)
                            OP_LOAD: begin
                                p               <= cmd_data;
                                remaining       <= CNTW'(1);
                                {npl, cpu, cpd} <= lines_for(OP_LOAD);
                                state           <= LO;
                            end
                            OP_UP, OP_DOWN: begin
                                if (cmd_len == '0) begin
                                    done  <= 1'b1;
                                    state <= DONE;
                                end else begin
                                    remaining       <= cmd_len;
                                    {npl, cpu, cpd} <= lines_for(cmd_op);
                                    state           <= LO;
                                end
                            end
                            default: begin
                                done  <= 1'b1;
                                state <= DONE;
                            end
                        endcase
                    end
                end
                LO: begin
                    if (phase == '0) begin
                        // This edge ends the LO phase: the counter's terminal flag is valid now.
                        if (((op_q == OP_UP) && !ntcu) || ((op_q == OP_DOWN) && !ntcd)) begin
                            if (wraps != '1) begin
                                wraps <= wraps + CNTW'(1);
                            end
                        end
                        {npl, cpu, cpd} <= 3'b111;
                        remaining       <= remaining - CNTW'(1);
                        phase           <= HI_LAST;
                        state           <= HI;
                    end else begin
                        phase <= phase - PW'(1);
                    end
                end
                HI: begin
                    if (phase == '0) begin
                        if (remaining == '0 || abort_req || abort_now) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            {npl, cpu, cpd} <= lines_for(op_q);
                            phase           <= LO_LAST;
                            state           <= LO;
                        end
                    end else begin
                        phase <= phase - PW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_193_driver.sv
// tb/tb_counter_193_driver.sv - self-checking bench for counter_193_driver with a behavioural 74x193 counter
module tb_counter_193_driver;

    localparam int WIDTH = 4;
    localparam int CNTW  = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic             cmd_valid;
    logic             sel;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic [CNTW-1:0]  cmd_len;
    logic             abort;
    logic             ntcu, ntcd;

    logic             ready_a, npl_a, cpu_a, cpd_a, done_a;
    logic [WIDTH-1:0] p_a;
    logic [CNTW-1:0]  wraps_a;
    logic             ready_b, npl_b, cpu_b, cpd_b, done_b;
    logic [WIDTH-1:0] p_b;
    logic [CNTW-1:0]  wraps_b;

    logic             valid_a, valid_b, abort_a, abort_b;
    assign valid_a = cmd_valid & !sel;
    assign valid_b = cmd_valid & sel;
    assign abort_a = abort & !sel;
    assign abort_b = abort & sel;

    counter_193_driver #(.WIDTH(WIDTH), .CNTW(CNTW), .PULSE_LO(1), .PULSE_HI(1)) dut_a (
        .clk(clk), .reset(reset), .cmd_valid(valid_a), .cmd_ready(ready_a), .cmd_op(cmd_op),
        .cmd_data(cmd_data), .cmd_len(cmd_len), .npl(npl_a), .cpu(cpu_a), .cpd(cpd_a), .p(p_a),
        .ntcu(ntcu), .ntcd(ntcd),
`ifdef COUNTER_DRIVER_ABORT_EN
        .abort(abort_a),
`endif
        .done(done_a), .wraps(wraps_a)
    );

    counter_193_driver #(.WIDTH(WIDTH), .CNTW(CNTW), .PULSE_LO(3), .PULSE_HI(2)) dut_b (
        .clk(clk), .reset(reset), .cmd_valid(valid_b), .cmd_ready(ready_b), .cmd_op(cmd_op),
        .cmd_data(cmd_data), .cmd_len(cmd_len), .npl(npl_b), .cpu(cpu_b), .cpd(cpd_b), .p(p_b),
        .ntcu(ntcu), .ntcd(ntcd),
`ifdef COUNTER_DRIVER_ABORT_EN
        .abort(abort_b),
`endif
        .done(done_b), .wraps(wraps_b)
    );

    // Observed view of whichever driver is currently selected; the other one sits idle with lines high.
    logic             ready_m, npl_m, cpu_m, cpd_m, done_m;
    logic [WIDTH-1:0] p_m;
    logic [CNTW-1:0]  wraps_m;
    assign ready_m = sel ? ready_b : ready_a;
    assign npl_m   = sel ? npl_b   : npl_a;
    assign cpu_m   = sel ? cpu_b   : cpu_a;
    assign cpd_m   = sel ? cpd_b   : cpd_a;
    assign done_m  = sel ? done_b  : done_a;
    assign p_m     = sel ? p_b     : p_a;
    assign wraps_m = sel ? wraps_b : wraps_a;

    // Behavioural 74x193: async load while npl low, counts on rising cpu/cpd.
    logic [3:0] q;
    logic       cpu_prev = 1'b1;
    logic       cpd_prev = 1'b1;
    always @(negedge clk) begin
        if (!npl_m)                  q <= p_m;
        else if (cpu_m && !cpu_prev) q <= q + 4'd1;
        else if (cpd_m && !cpd_prev) q <= q - 4'd1;
        cpu_prev <= cpu_m;
        cpd_prev <= cpd_m;
    end
    assign ntcu = !((q === 4'hF) && !cpu_m);
    assign ntcd = !((q === 4'h0) && !cpd_m);

    int         vecs = 0;
    int         errs = 0;
    logic [3:0] exp_q;
    logic       q_known = 1'b0;
    logic [3:0] exp_p [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Terminal counts crossed by n pulses starting from q0, computed arithmetically.
    function automatic int model_wraps(input int q0, input logic [1:0] op, input int n);
        int w = 0;
        for (int k = 0; k < n; k++) begin
            if (op == 2'b10 && ((q0 + k) % 16) == 15) w++;
            if (op == 2'b11 && ((q0 - k + 4096) % 16) == 0) w++;
        end
        return (w > 255) ? 255 : w;
    endfunction

    task automatic run_cmd(input string tag, input logic [1:0] op, input logic [3:0] data,
                           input logic [7:0] len, input int pl, input int ph, input int abort_at);
        int   n, period, cyc, pulses, bad, done_cyc, last;
        logic line, prev, exp_low;
        logic [2:0] others;
        n = (op == 2'b00) ? 0 : (op == 2'b01) ? 1 : int'(len);
        if (abort_at > 0 && abort_at < n) n = abort_at;
        period = pl + ph;
        last = n * period + 2;
        @(negedge clk);
        cmd_op = op; cmd_data = data; cmd_len = len; cmd_valid = 1'b1;
        cyc = 0;
        while (!ready_m && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, " ready"}, 32'(ready_m), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        bad = 0; pulses = 0; prev = 1'b1; done_cyc = -1;
        for (int i = 1; i <= last; i++) begin
            abort = 1'b0;
            exp_low = (i <= n * period) && (((i - 1) % period) < pl);
            case (op)
                2'b01:   begin line = npl_m; others = {1'b1, cpu_m, cpd_m}; end
                2'b10:   begin line = cpu_m; others = {npl_m, 1'b1, cpd_m}; end
                2'b11:   begin line = cpd_m; others = {npl_m, cpu_m, 1'b1}; end
                default: begin line = 1'b1;  others = {npl_m, cpu_m, cpd_m}; end
            endcase
            if (line !== !exp_low) bad++;
            if (others !== 3'b111) bad++;
            if (prev && !line) begin
                pulses++;
                if (abort_at > 0 && pulses == abort_at) abort = 1'b1;
            end
            prev = line;
            if (done_m === 1'b1) begin
                if (done_cyc < 0) done_cyc = i;
                else bad++;
            end
            if (i == last) chk({tag, " ready_after"}, 32'(ready_m), 32'd1);
            else @(negedge clk);
        end
        abort = 1'b0;
        chk({tag, " wave"}, 32'(bad), 32'd0);
        chk({tag, " pulses"}, 32'(pulses), 32'(n));
        chk({tag, " done_cycle"}, 32'(done_cyc), 32'(n * period + 1));
        if (op == 2'b01) begin
            exp_p[sel] = data;
            exp_q = data;
            q_known = 1'b1;
        end
        chk({tag, " p"}, 32'(p_m), 32'(exp_p[sel]));
        if (op[1] && q_known) begin
            chk({tag, " wraps"}, 32'(wraps_m), 32'(model_wraps(int'(exp_q), op, n)));
            exp_q = (op == 2'b10) ? exp_q + 4'(n) : exp_q - 4'(n);
        end else if (!op[1]) begin
            chk({tag, " wraps"}, 32'(wraps_m), 32'd0);
        end
        if (q_known) chk({tag, " q"}, 32'(q), 32'(exp_q));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, dones;
        logic [1:0] rop;
        reset = 1'b1; cmd_valid = 1'b0; sel = 1'b0; abort = 1'b0;
        cmd_op = 2'b00; cmd_data = '0; cmd_len = '0;
        exp_p[0] = '0; exp_p[1] = '0;

        // Reset held for three cycles.
        repeat (3) @(negedge clk);
        chk("reset lines", 32'({npl_m, cpu_m, cpd_m}), 32'b111);
        chk("reset p", 32'(p_m), 32'd0);
        chk("reset ready", 32'(ready_m), 32'd0);
        chk("reset done", 32'(done_m), 32'd0);
        chk("reset wraps", 32'(wraps_m), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("ready after release", 32'(ready_m), 32'd1);

        run_cmd("load_d", 2'b01, 4'hD, 8'd0, 1, 1, 0);
        run_cmd("load_e", 2'b01, 4'hE, 8'd0, 1, 1, 0);
        run_cmd("up3", 2'b10, 4'h0, 8'd3, 1, 1, 0);
        run_cmd("up_len0", 2'b10, 4'h0, 8'd0, 1, 1, 0);
        run_cmd("nop", 2'b00, 4'h0, 8'd5, 1, 1, 0);

        // Wider pulses on the second driver.
        sel = 1'b1;
        run_cmd("b_load1", 2'b01, 4'h1, 8'd0, 3, 2, 0);
        run_cmd("b_down2", 2'b11, 4'h0, 8'd2, 3, 2, 0);
        sel = 1'b0;

`ifdef COUNTER_DRIVER_ABORT_EN
        run_cmd("ab_load", 2'b01, 4'h3, 8'd0, 1, 1, 0);
        run_cmd("ab_up20", 2'b10, 4'h0, 8'd20, 1, 1, 4);
`endif

        // Reset in the middle of a long count.
        @(negedge clk);
        cmd_op = 2'b10; cmd_len = 8'd10; cmd_valid = 1'b1;
        cyc = 0;
        while (!ready_m && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midreset lines", 32'({npl_m, cpu_m, cpd_m}), 32'b111);
        chk("midreset ready", 32'(ready_m), 32'd0);
        chk("midreset wraps", 32'(wraps_m), 32'd0);
        reset = 1'b0;
        exp_p[0] = '0; exp_p[1] = '0; q_known = 1'b0;
        dones = 0;
        for (int i = 0; i < 25; i++) begin
            if (done_m === 1'b1) dones++;
            @(negedge clk);
        end
        chk("midreset no_done", 32'(dones), 32'd0);
        chk("midreset idle", 32'(ready_m), 32'd1);

        // Randomized commands checked against the arithmetic model.
        run_cmd("rnd_load0", 2'b01, 4'($urandom_range(0, 15)), 8'd0, 1, 1, 0);
        for (int t = 0; t < 14; t++) begin
            rop = 2'($urandom_range(0, 3));
            run_cmd($sformatf("rnd%0d", t), rop, 4'($urandom_range(0, 15)),
                    8'($urandom_range(0, 20)), 1, 1, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
